// File: rtl/data_mem_wbuf_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
//   Shared types and constants for the data-memory stage with posted write
//   buffer (data_mem_wbuf).
//   - DEF_ADDR_W / DEF_DATA_W : default address / word widths
//   - wb_entry_t              : one write-buffer entry {addr, data}
//   - drain_state_t           : array drain FSM states
//   - MMIO_RESULT_ADDR        : word address of the MMIO result register
//                               (only decoded with DATA_MEM_WBUF_MMIO_RESULT_EN)
// -----------------------------------------------------------------------------
package data_mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } drain_state_t;

   // Top word of the address space.
   localparam logic [DEF_ADDR_W-1:0] MMIO_RESULT_ADDR = '1;

endpackage

// File: rtl/data_mem_wbuf_if.sv
// -----------------------------------------------------------------------------
// data_mem_wbuf_if
//   Core <-> data-memory bus.
//   master (core)   : drives d_addr, w_data, d_wr, d_rd; receives r_data, stall
//   slave  (memory) : receives the request; drives r_data, stall
//   r_data and stall are combinational in the slave.
// -----------------------------------------------------------------------------
interface data_mem_wbuf_if
   import data_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic [15:0]       d_addr;
   logic [DATA_W-1:0] w_data;
   logic              d_wr;
   logic              d_rd;
   logic [DATA_W-1:0] r_data;
   logic              stall;

   modport master (output d_addr, w_data, d_wr, d_rd, input  r_data, stall);
   modport slave  (input  d_addr, w_data, d_wr, d_rd, output r_data, stall);
endinterface

// File: rtl/data_mem_wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
//   Circular FIFO of posted stores with a youngest-first address search.
//   Ports:
//     clk, rst                 clock, async active-low reset (pointers/count)
//     push, push_addr/data     enqueue at tail (caller guarantees !full)
//     pop                      dequeue head (caller guarantees count>0)
//     head_addr/head_data      oldest entry, the one being drained
//     count, full              occupancy
//     srch_addr -> hit/hit_data youngest valid entry matching srch_addr
//   Entry storage is not reset; validity comes from head/count only.
// -----------------------------------------------------------------------------
module wbuf_fifo #(
   parameter  int ADDR_W = 8,
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 4,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [CW-1:0]     count,
   output logic              full,
   input  logic [ADDR_W-1:0] srch_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PW-1:0]     head, tail;
   logic [DEPTH-1:0]  match;

   assign full      = (count == CW'(DEPTH));
   assign head_addr = mem[head].addr;
   assign head_data = mem[head].data;

   // Per-slot compare; a slot is live when its age (distance from head)
   // is below the occupancy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_cam
      logic [PW-1:0] age;
      assign age      = PW'(i) - head;
      assign match[i] = ({1'b0, age} < count) && (mem[i].addr == srch_addr);
   end

   // Walk oldest -> youngest so the youngest hit is the last one written.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (match[idx]) begin
            hit      = 1'b1;
            hit_data = mem[idx].data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= '{addr: push_addr, data: push_data};
   end

endmodule

// File: rtl/data_mem_wbuf.sv
// -----------------------------------------------------------------------------
// data_mem_wbuf
//   Data-memory stage behind the 16-bit MIPS core. Stores are posted into a
//   small write buffer and drained into a single-ported array in the
//   background (WR_CYCLES clocks per write); loads forward from the buffer.
//   Ports:
//     clk, rst      clock, async active-low reset
//     bus (slave)   d_addr/w_data/d_wr/d_rd in, r_data/stall out (comb.)
//     wb_count      buffer occupancy (debug)
//     result        MMIO result register
//     result_valid  one-cycle pulse after a result write
//   Option macro: DATA_MEM_WBUF_MMIO_RESULT_EN
//     defined   : store to the top word loads `result` instead of the array,
//                 never stalls; load of that word returns `result`.
//     undefined : top word is ordinary memory, result/result_valid tied 0.
//   Load+store together is a core protocol violation: the load is served
//   and the store is held off with stall.
// -----------------------------------------------------------------------------
module data_mem_wbuf
   import data_mem_pkg::*;
#(
   parameter  int ADDR_W    = DEF_ADDR_W,
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int WB_DEPTH  = 4,
   parameter  int WR_CYCLES = 2,
   localparam int CW        = $clog2(WB_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_wbuf_if.slave    bus,
   output logic [CW-1:0]     wb_count,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);
   localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic [ADDR_W-1:0] addr;
   logic              is_mmio;
   logic              push, do_write, start_drain;
   logic              full, hit;
   logic [DATA_W-1:0] hit_data, head_data;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] rd_data;
   logic              stall_c;
   drain_state_t      state;
   logic [CNT_W-1:0]  cnt;

   // Upper address bits alias onto the array.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.d_addr[15:ADDR_W];
   assign addr           = bus.d_addr[ADDR_W-1:0];

`ifdef DATA_MEM_WBUF_MMIO_RESULT_EN
   logic mmio_wr;
   assign is_mmio = (addr == ADDR_W'(MMIO_RESULT_ADDR));
   assign mmio_wr = bus.d_wr && !bus.d_rd && is_mmio;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= mmio_wr;
         if (mmio_wr) result <= bus.w_data;
      end
   end
`else
   assign is_mmio      = 1'b0;
   assign result       = '0;
   assign result_valid = 1'b0;
`endif

   assign push = bus.d_wr && !bus.d_rd && !is_mmio && !full;

   wbuf_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (WB_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (addr),
      .push_data (bus.w_data),
      .pop       (do_write),
      .head_addr (head_addr),
      .head_data (head_data),
      .count     (wb_count),
      .full      (full),
      .srch_addr (addr),
      .hit       (hit),
      .hit_data  (hit_data)
   );

   // A pending load keeps the drain from starting, so a miss seen in IDLE
   // can always read the array port this cycle.
   assign start_drain = (state == IDLE) && (wb_count != '0) && !bus.d_rd;
   assign do_write    = ((state == BUSY) && (cnt == '0)) ||
                        (start_drain && (WR_CYCLES == 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (start_drain && (WR_CYCLES > 1)) begin
               state <= BUSY;
               cnt   <= CNT_W'(WR_CYCLES - 1);
            end
            BUSY: if (cnt == '0) state <= IDLE;
                  else           cnt   <= cnt - CNT_W'(1);
            default: state <= IDLE;
         endcase
      end
   end

   // Reset forces IDLE asynchronously, so an in-flight write never lands.
   always_ff @(posedge clk) begin
      if (do_write) mem[head_addr] <= head_data;
   end

   always_comb begin
      rd_data = '0;
      stall_c = 1'b0;
      if (bus.d_rd) begin
         if (is_mmio)             rd_data = result;
         else if (hit)            rd_data = hit_data;
         else if (state == IDLE)  rd_data = mem[addr];
         else                     stall_c = 1'b1;
         if (bus.d_wr)            stall_c = 1'b1;
      end else if (bus.d_wr) begin
         stall_c = full && !is_mmio;
      end
   end

   assign bus.r_data = rd_data;
   assign bus.stall  = stall_c;

endmodule

// File: tb/tb_data_mem_wbuf.sv
module tb_data_mem_wbuf;
   localparam int WR_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  wb_count;
   logic [15:0] result;
   logic        result_valid;

   data_mem_wbuf_if #(.DATA_W(16)) bus ();

   data_mem_wbuf dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .wb_count     (wb_count),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] shadow [256];   // latest value the core stored per word
   logic [15:0] exp_q [$];      // load scoreboard

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic idle(input int n);
      bus.d_wr = 1'b0;
      bus.d_rd = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [15:0] a, input logic [15:0] d, output int stalls);
      bit done = 0;
      bus.d_addr = a; bus.w_data = d; bus.d_wr = 1'b1; bus.d_rd = 1'b0;
      stalls = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!bus.stall) done = 1;
         else stalls++;
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL store_timeout: addr %h still stalled after 50 cycles", a);
      end else begin
         shadow[a[7:0]] = d;
      end
      @(posedge clk); #1;
      bus.d_wr = 1'b0;
   endtask

   task automatic issue_load(input logic [15:0] a, output logic [15:0] got, output int stalls);
      bit done = 0;
      exp_q.push_back(shadow[a[7:0]]);
      bus.d_addr = a; bus.d_rd = 1'b1; bus.d_wr = 1'b0;
      stalls = 0;
      got = 16'hxxxx;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!bus.stall) begin done = 1; got = bus.r_data; end
         else stalls++;
      end
      @(posedge clk); #1;
      bus.d_rd = 1'b0;
   endtask

   task automatic wait_empty(output int cyc, output bit to);
      bus.d_wr = 1'b0; bus.d_rd = 1'b0;
      cyc = 0; to = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (wb_count == 3'd0) begin to = 0; break; end
         cyc++;
      end
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.d_addr = '0; bus.w_data = '0; bus.d_wr = 1'b0; bus.d_rd = 1'b0;
      #2 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL reset_wb_count: got %0d want 0", wb_count); end
      n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
      n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      n_cmp++; if (bus.r_data !== 16'h0) begin n_fail++; $display("FAIL reset_r_data_noload: got %h want 0000", bus.r_data); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic preload();
      int st, cyc; bit to;
      do_store(16'h0010, 16'h5555, st);
      do_store(16'h0041, 16'h4141, st);
      wait_empty(cyc, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL preload_drain: wb_count=%0d never reached 0", wb_count); end
   endtask

   task automatic test_forwarding();
      int st, cyc; bit to; logic [15:0] got, e;
      do_store(16'h0020, 16'hAAAA, st);
      do_store(16'h0020, 16'hBBBB, st);
      issue_load(16'h0020, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL fwd_data: got %h want %h", got, e); end
      n_cmp++; if (st != 0) begin n_fail++; $display("FAIL fwd_stall: stalled %0d cycles want 0", st); end
      wait_empty(cyc, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL fwd_drain: wb_count=%0d never reached 0", wb_count); end
      issue_load(16'h0020, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL fwd_array_data: got %h want %h", got, e); end
   endtask

   task automatic test_wrap();
      int st, cyc; bit to; logic [15:0] got, e;
      do_store(16'h0150, 16'h1501, st);
      wait_empty(cyc, to);
      issue_load(16'h0050, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL wrap_0050: got %h want %h", got, e); end
      issue_load(16'hAB50, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL wrap_AB50: got %h want %h", got, e); end
   endtask

   task automatic test_rd_wr_collision();
      bus.d_addr = 16'h0020; bus.w_data = 16'hDEAD; bus.d_rd = 1'b1; bus.d_wr = 1'b1;
      $display("NOTE: d_rd and d_wr driven together at %0t (core protocol violation)", $time);
      @(negedge clk);
      n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL coll_stall: got %b want 1", bus.stall); end
      n_cmp++; if (bus.r_data !== shadow[8'h20]) begin n_fail++; $display("FAIL coll_r_data: got %h want %h", bus.r_data, shadow[8'h20]); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL coll_no_push: wb_count %0d want 0", wb_count); end
      idle(1);
   endtask

   task automatic test_buffer_full();
      int st, cyc; bit to; int stalls [5]; logic [15:0] got, e;
      do_store(16'h002F, 16'h2F2F, st);
      idle(1);
      for (int i = 0; i < 5; i++) do_store(16'h0030 + 16'(i), 16'h3000 + 16'(i), stalls[i]);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (stalls[i] != ((i == 4) ? 1 : 0)) begin
            n_fail++; $display("FAIL full_stall_%0d: stalled %0d cycles want %0d", i, stalls[i], (i == 4) ? 1 : 0);
         end
      end
      for (int i = 0; i < 6; i++) begin
         issue_load(16'h002F + 16'(i), got, st);
         e = exp_q.pop_front();
         n_cmp++; if (got !== e) begin n_fail++; $display("FAIL full_load_%0d: got %h want %h", i, got, e); end
      end
      wait_empty(cyc, to);
      n_cmp++; if (to) begin n_fail++; $display("FAIL full_drain: wb_count=%0d never reached 0", wb_count); end
   endtask

   task automatic test_miss_busy();
      int st, cyc; bit to; logic [15:0] got, e;
      do_store(16'h0040, 16'h4040, st);
      idle(1);
      issue_load(16'h0041, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL miss_busy_data: got %h want %h", got, e); end
      n_cmp++; if (st != WR_CYCLES) begin n_fail++; $display("FAIL miss_busy_stall: stalled %0d cycles want %0d", st, WR_CYCLES); end
      wait_empty(cyc, to);
   endtask

   task automatic test_drain();
      int st, cyc; bit to; logic [15:0] got, e;
      for (int i = 0; i < 4; i++) do_store(16'h0060 + 16'(i), 16'h6000 + 16'(i * 17), st);
      wait_empty(cyc, to);
      n_cmp++;
      if (to || cyc < 3 * WR_CYCLES || cyc > 4 * (WR_CYCLES + 1)) begin
         n_fail++; $display("FAIL drain_time: %0d cycles (timeout=%0b) want %0d..%0d", cyc, to, 3 * WR_CYCLES, 4 * (WR_CYCLES + 1));
      end
      for (int i = 0; i < 4; i++) begin
         issue_load(16'h0060 + 16'(i), got, st);
         e = exp_q.pop_front();
         n_cmp++; if (got !== e) begin n_fail++; $display("FAIL drain_load_%0d: got %h want %h", i, got, e); end
         n_cmp++; if (st != 0) begin n_fail++; $display("FAIL drain_load_stall_%0d: %0d want 0", i, st); end
      end
   endtask

   task automatic test_reset_mid_drain();
      int st; logic [15:0] old, got, e;
      old = shadow[8'h10];
      do_store(16'h0010, 16'h1234, st);
      bus.d_wr = 1'b0;
      @(posedge clk); #2;          // drain now in progress
      rst = 1'b0;
      #1;
      n_cmp++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", wb_count); end
      @(posedge clk); #1 rst = 1'b1;
      shadow[8'h10] = old;         // the abandoned write must not land
      issue_load(16'h0041, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (st != 0) begin n_fail++; $display("FAIL rst_mid_idle: miss stalled %0d cycles want 0", st); end
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL rst_mid_load41: got %h want %h", got, e); end
      issue_load(16'h0010, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL rst_mid_old_value: got %h want %h", got, e); end
   endtask

`ifdef DATA_MEM_WBUF_MMIO_RESULT_EN
   task automatic test_mmio();
      int st, cyc; bit to; logic [15:0] got, e;
      for (int i = 0; i < 5; i++) do_store(16'h0070 + 16'(i), 16'h7000 + 16'(i), st);
      bus.d_addr = 16'h00FF; bus.w_data = 16'h000D; bus.d_wr = 1'b1; bus.d_rd = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mmio_stall: got %b want 0", bus.stall); end
      n_cmp++; if (wb_count !== 3'd4) begin n_fail++; $display("FAIL mmio_full_before: wb_count %0d want 4", wb_count); end
      @(posedge clk); #1 bus.d_wr = 1'b0;
      @(negedge clk);
      n_cmp++; if (result !== 16'h000D) begin n_fail++; $display("FAIL mmio_result: got %h want 000d", result); end
      n_cmp++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL mmio_valid_hi: got %b want 1", result_valid); end
      n_cmp++; if (wb_count !== 3'd4) begin n_fail++; $display("FAIL mmio_count: wb_count %0d want 4", wb_count); end
      @(negedge clk);
      n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL mmio_valid_lo: got %b want 0", result_valid); end
      @(posedge clk); #1;
      shadow[8'hFF] = 16'h000D;
      issue_load(16'h00FF, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL mmio_load: got %h want %h", got, e); end
      wait_empty(cyc, to);
      for (int i = 0; i < 5; i++) begin
         issue_load(16'h0070 + 16'(i), got, st);
         e = exp_q.pop_front();
         n_cmp++; if (got !== e) begin n_fail++; $display("FAIL mmio_bg_load_%0d: got %h want %h", i, got, e); end
      end
   endtask
`else
   task automatic test_ff_plain();
      int st, cyc; bit to; logic [15:0] got, e;
      do_store(16'h00FF, 16'h00EE, st);
      @(negedge clk);
      n_cmp++; if (result_valid !== 1'b0 || result !== 16'h0) begin
         n_fail++; $display("FAIL ff_no_result: result %h valid %b want 0000/0", result, result_valid);
      end
      wait_empty(cyc, to);
      issue_load(16'h00FF, got, st);
      e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_fail++; $display("FAIL ff_plain_load: got %h want %h", got, e); end
   endtask
`endif

   initial begin
      test_reset();
      preload();
      test_forwarding();
      test_wrap();
      test_rd_wr_collision();
      test_buffer_full();
      test_miss_busy();
      test_drain();
      test_reset_mid_drain();
`ifdef DATA_MEM_WBUF_MMIO_RESULT_EN
      test_mmio();
`else
      test_ff_plain();
`endif
      n_cmp++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
